// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main multicycle controller (master)
// and the MULT/DIV sequencer (slave).
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply or restoring
// divide on operand magnitudes, one bit per clock, with sign fix-up at the end.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_div_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // mult: product:multiplier, div: remainder:quotient
    logic [CW-1:0]      cnt_q;
    logic               neg_res_q;   // product / quotient sign
    logic               neg_rem_q;   // remainder follows the dividend
    logic               dbz_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_out_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_signed;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_acc_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;

    // Operand magnitudes, one multiply/divide step, and sign-corrected results.
    always_comb begin
        is_signed = ~op_q[0];
        is_div    = op_q[1];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag     = a_neg ? -a_q : a_q;
        b_mag     = b_neg ? -b_q : b_q;

        // Carry out of the upper-half add lands in the MSB after the shift.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

        // Shifted remainder needs WIDTH+1 bits: it can exceed the divisor's range.
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_sh - {1'b0, opnd_q};
        rem_ge    = (rem_sh >= {1'b0, opnd_q});
        div_acc_d = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], rem_ge};

        prod_d    = neg_res_q ? -acc_q : acc_q;
        quo_d     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= '0;
                    if (is_div) begin
                        acc_q  <= {{WIDTH{1'b0}}, a_mag};
                        opnd_q <= b_mag;
                    end else begin
                        acc_q  <= {{WIDTH{1'b0}}, b_mag};
                        opnd_q <= a_mag;
                    end
                    if (is_div && (b_q == '0)) begin
                        dbz_q   <= 1'b1;
                        state_q <= S_FIX;
                    end else begin
                        dbz_q   <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= is_div ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dbz_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end else begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: results, latency, handshake and reset.
module tb_mult_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;
    bit   busy_bad;

    always #5 clk = ~clk;

    mult_div_ctrl_if #(.WIDTH(W)) bus ();

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge; returns #1 after the accepting edge E0.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Count edges until done; busy must stay high before done and be low with it.
    task automatic wait_done(output int edges, output bit bad);
        edges = 0;
        bad   = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                edges = i;
                if (bus.busy) bad = 1'b1;
                break;
            end else if (!bus.busy) begin
                bad = 1'b1;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int  e;
        bit  bb;
        launch(op, a, b, 1'b0);
        check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        wait_done(e, bb);
        check({tag, "_latency"}, e, 34);
        check({tag, "_busy"}, 32'(bb), 32'd0);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d", op, a, b, bus.hi, bus.lo, e);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_check("mult_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_check("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_check("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_check("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_check("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_check("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        // Divide by zero short path
        launch(2'b11, 32'h1234, 32'h0, 1'b0);
        wait_done(n, busy_bad);
        check("dbz_latency", n, 2);
        check("dbz_flag", 32'(bus.div_by_zero), 32'd1);
        check("dbz_hi", bus.hi, 32'h1234);
        check("dbz_lo", bus.lo, 32'hFFFF_FFFF);
        $display("divu by zero -> hi=%h lo=%h dbz=%0d edges=%0d", bus.hi, bus.lo, bus.div_by_zero, n);
        @(posedge clk);
        #1;
        check("dbz_pulse", 32'(bus.div_by_zero), 32'd0);

        // Start pulsed mid-RUN with other operands must be ignored
        launch(2'b01, 32'h1234_5678, 32'h10, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n, busy_bad);
        check("ign_latency", n + 6, 34);
        check("ign_hi", bus.hi, 32'h1);
        check("ign_lo", bus.lo, 32'h2345_6780);
        $display("ignored start -> hi=%h lo=%h edges=%0d", bus.hi, bus.lo, n + 6);
        @(posedge clk);
        #1;
        check("ign_no_queue", 32'(bus.busy), 32'd0);

        // Start held through done; operands toggled during the first run
        launch(2'b11, 32'd100, 32'd7, 1'b1);
        bus.op = 2'b01;
        bus.a  = 32'hFFFF_FFFF;
        bus.b  = 32'hFFFF_FFFF;
        wait_done(n, busy_bad);
        check("held1_latency", n, 34);
        check("held1_hi", bus.hi, 32'd2);
        check("held1_lo", bus.lo, 32'd14);
        $display("held start first -> hi=%h lo=%h edges=%0d", bus.hi, bus.lo, n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("held2_busy", 32'(bus.busy), 32'd1);
        check("held2_hold_lo", bus.lo, 32'd14);
        wait_done(n, busy_bad);
        check("held2_latency", n, 34);
        check("held2_busy_ok", 32'(busy_bad), 32'd0);
        check("held2_hi", bus.hi, 32'hFFFF_FFFE);
        check("held2_lo", bus.lo, 32'h1);
        $display("held start second -> hi=%h lo=%h edges=%0d", bus.hi, bus.lo, n);

        // Asynchronous reset in the middle of RUN
        launch(2'b01, 32'd5, 32'd7, 1'b0);
        repeat (11) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        $display("reset mid-run -> busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        reset_n = 1'b1;
        run_check("after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
